// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit add/subtract built around one
// 4-bit carry-lookahead slice. Operands are latched on accept, then one
// nibble is processed per clock (LSB first) with the carry registered
// between nibbles. Valid/ready handshake on both the operand and result side.
//
// Optional build macro: NIBBLE_ADD_FLAGS_EN
//   defined     -> ports v (signed overflow) and z (zero) exist, registered
//                  when the result is completed.
//   not defined -> v/z ports and their logic are absent.
module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef NIBBLE_ADD_FLAGS_EN
    ,
    output logic             v,
    output logic             z
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             co_r;
    logic             in_ready_r;
    logic             out_valid_r;
`ifdef NIBBLE_ADD_FLAGS_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             v_r;
    logic             z_r;
`endif

    logic [WIDTH-1:0] b_eff_s;
    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [4:0]       slice_s;
    logic [WIDTH-1:0] s_final_s;

    // Operand conditioning and the single nibble slice for the current count.
    always_comb begin
        b_eff_s   = sub ? ~b : b;
        nib_a_s   = a_r[{cnt_r, 2'b00} +: 4];
        nib_b_s   = b_r[{cnt_r, 2'b00} +: 4];
        slice_s   = cla4(nib_a_s, nib_b_s, carry_r);
        // Full result as it will look once the top nibble is written;
        // only meaningful on the last RUN edge.
        s_final_s = s_r;
        s_final_s[WIDTH-1 -: 4] = slice_s[3:0];
    end

    // Handshake FSM, operand latches, nibble datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            carry_r     <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            s_r         <= {WIDTH{1'b0}};
            co_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef NIBBLE_ADD_FLAGS_EN
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            v_r         <= 1'b0;
            z_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b_eff_s;
                        // Subtraction is a + ~b + 1, so ci is replaced by 1.
                        carry_r    <= sub ? 1'b1 : ci;
                        cnt_r      <= CNT_ZERO;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_RUN;
`ifdef NIBBLE_ADD_FLAGS_EN
                        a_msb_r    <= a[WIDTH-1];
                        b_msb_r    <= b_eff_s[WIDTH-1];
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Partial nibbles overwrite the previous result in place.
                    s_r[{cnt_r, 2'b00} +: 4] <= slice_s[3:0];
                    carry_r                  <= slice_s[4];
                    if (cnt_r == CNT_LAST) begin
                        co_r        <= slice_s[4];
                        cnt_r       <= CNT_ZERO;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
`ifdef NIBBLE_ADD_FLAGS_EN
                        v_r <= (a_msb_r == b_msb_r) & (slice_s[3] != a_msb_r);
                        z_r <= (s_final_s == {WIDTH{1'b0}});
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Handoff edge only returns to IDLE; no accept here.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= CNT_ZERO;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign co        = co_r;
`ifdef NIBBLE_ADD_FLAGS_EN
    assign v         = v_r;
    assign z         = z_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=32). A transaction-level
// reference model (plain integer arithmetic plus a latency countdown) is
// compared against the DUT on every falling edge; directed vectors also carry
// hand-computed literal results that pin both the DUT and the model.
module tb_nibble_serial_adder;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef NIBBLE_ADD_FLAGS_EN
    logic             v;
    logic             z;
`endif

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef NIBBLE_ADD_FLAGS_EN
        ,
        .v         (v),
        .z         (z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_s;
    logic             m_co, m_v, m_z;
    bit               m_idle  = 1'b1;
    bit               m_valid = 1'b0;
    int               m_wait  = 0;

    // Transaction model: result from integer arithmetic, ready NIB edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_wait  = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                longint sa, sb, res;
                longint unsigned ua, ub;
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ua = longint'(a);
                ub = longint'(b);
                res = sub ? (sa - sb) : (sa + sb + longint'(ci));
                m_s  = res[WIDTH-1:0];
                m_co = sub ? (a >= b) : ((ua + ub + longint'(ci)) > 64'h0000_0000_FFFF_FFFF);
                m_v  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
                m_z  = (res[WIDTH-1:0] == 32'h0);
                m_idle = 1'b0;
                m_wait = NIB;
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("in_ready", 64'(in_ready), 64'(m_idle));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("s", 64'(s), 64'(m_s));
                chk("co", 64'(co), 64'(m_co));
`ifdef NIBBLE_ADD_FLAGS_EN
                chk("v", 64'(v), 64'(m_v));
                chk("z", 64'(z), 64'(m_z));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present one operand set, wait for out_valid; lat = edges after accept.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib,
                         input logic ici, input logic isub, output int lat);
        @(negedge clk);
        a = ia; b = ib; ci = ici; sub = isub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NIB));
    endtask

    task automatic lit(input string name, input logic [31:0] es, input logic eco,
                       input logic ev, input logic ez);
        chk({name, "_s"}, 64'(s), 64'(es));
        chk({name, "_co"}, 64'(co), 64'(eco));
        chk({name, "_model_s"}, 64'(m_s), 64'(es));
        chk({name, "_model_co"}, 64'(m_co), 64'(eco));
        chk({name, "_model_v"}, 64'(m_v), 64'(ev));
        chk({name, "_model_z"}, 64'(m_z), 64'(ez));
`ifdef NIBBLE_ADD_FLAGS_EN
        chk({name, "_v"}, 64'(v), 64'(ev));
        chk({name, "_z"}, 64'(z), 64'(ez));
`endif
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff_out_valid", 64'(out_valid), 64'(1'b0));
        chk("handoff_in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Directed vector table: {a, b, ci, sub} -> {s, co, v, z}
    logic [31:0] tv_a   [6] = '{32'h12345678, 32'hA5A5A5A5, 32'h00000000, 32'h00000003, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tv_b   [6] = '{32'h11111111, 32'h5A5A5A5A, 32'h00000000, 32'h00000003, 32'h00000001, 32'h80000000};
    logic        tv_ci  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        tv_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tv_s   [6] = '{32'h23456789, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000000};
    logic        tv_co  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        tv_v   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        tv_z   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; ci = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_s", 64'(s), 64'(32'h0));
        chk("rst_co", 64'(co), 64'(1'b0));
`ifdef NIBBLE_ADD_FLAGS_EN
        chk("rst_v", 64'(v), 64'(1'b0));
        chk("rst_z", 64'(z), 64'(1'b0));
`endif
        @(negedge clk);
        reset = 1'b0;
        run_chk = 1'b1;

        // 1 + 4: carry ripple, then backpressure with a rejected new request
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        lit("t1", 32'h00000000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a = 32'h00000010; b = 32'h00000020; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_s", 64'(s), 64'(32'h0));
            chk("bp_co", 64'(co), 64'(1'b1));
            chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
            chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 64'(out_valid), 64'(1'b0));
        chk("bp_release_in_ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        out_ready = 1'b0;

        // 2: subtract with borrow, ci ignored
        do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, lat);
        lit("t2", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        handoff();

        // 3: signed overflow both directions
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, lat);
        lit("t3a", 32'h80000000, 1'b0, 1'b1, 1'b0);
        handoff();
        do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, lat);
        lit("t3b", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        handoff();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_op(tv_a[i], tv_b[i], tv_ci[i], tv_sub[i], lat);
            lit($sformatf("tv%0d", i), tv_s[i], tv_co[i], tv_v[i], tv_z[i]);
            handoff();
        end

        // 5: reset after 3 RUN cycles aborts the operation
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        chk("midrst_s", 64'(s), 64'(32'h0));
        @(negedge clk);
        reset = 1'b0;
        do_op(32'h00000001, 32'h00000002, 1'b1, 1'b0, lat);
        lit("t5", 32'h00000004, 1'b0, 1'b0, 1'b0);
        handoff();

        repeat (2) @(posedge clk);
        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
